pixel_sensor_sequencer: RTL and testbench
=========================================

# pixel_sensor_sequencer

Frame-level controller for the pixel array: sequences the erase, expose, convert and readout phases of one image capture. During convert it drives the shared ADC ramp count. During readout it walks row and column-group selects over the array, presenting OUTPUT_BUS_WIDTH pixels per beat to the downstream output stage under a valid/ready handshake. It sits between the top-level capture request and the pixel array / output bus datapath.

## Interface
- PIXEL_ARRAY_HEIGHT, 12, rows in the array.
- PIXEL_ARRAY_WIDTH, 24, columns in the array. Must be a multiple of OUTPUT_BUS_WIDTH.
- PIXEL_BITS, 8, ADC/pixel register width.
- OUTPUT_BUS_WIDTH, 8, pixels transferred per beat.
- ERASE_CYCLES, 5, fixed erase phase length, ≥1.
- Derived: GROUPS = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH; RW = max(1,$clog2(PIXEL_ARRAY_HEIGHT)); GW = max(1,$clog2(GROUPS)).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  capture request; sampled only in IDLE.
- continuous  in  1  when 1 at the final beat handshake, the next frame begins without returning to IDLE.
- expose_cycles  in  16  exposure length; latched on the accepted start and on each continuous restart.
- out_ready  in  1  downstream accepts current beat.
- erase  out  1  high throughout ERASE.
- expose  out  1  high throughout EXPOSE.
- convert  out  1  high throughout CONVERT.
- adc_count  out  PIXEL_BITS  ramp value during CONVERT; 0 otherwise.
- row_sel  out  RW  row being read.
- col_group  out  GW  column group being read; pixels [col_group*OUTPUT_BUS_WIDTH +: OUTPUT_BUS_WIDTH].
- out_valid  out  1  beat valid on the output bus.
- first_beat  out  1  with out_valid: row 0, group 0.
- last_beat  out  1  with out_valid: last row, last group.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE → ERASE → EXPOSE → CONVERT → READ → (ERASE | IDLE).
- IDLE: all outputs 0. start=1 → ERASE next cycle; latch expose_cycles; a latched value of 0 is treated as 1.
- ERASE: exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: exactly the latched exposure count in cycles, then CONVERT.
- CONVERT: exactly 2^PIXEL_BITS cycles. adc_count = 0 on the first cycle and increments by 1 each cycle to 2^PIXEL_BITS−1. No wrap inside the phase. Then READ with row_sel=0, col_group=0.
- READ: out_valid=1 continuously. Beat transfer occurs on out_valid && out_ready.
  - On transfer, col_group increments. At GROUPS−1 it wraps to 0 and row_sel increments.
  - Transfer of the last beat ends READ.
  - Without out_ready, row_sel and col_group hold; out_valid must not drop.
- End of READ: continuous=1 → ERASE, with expose_cycles re-latched. Otherwise → IDLE.
- start outside IDLE is ignored and not queued. expose_cycles changes outside latch points have no effect.
- Beats per frame: PIXEL_ARRAY_HEIGHT*GROUPS, which is 36 at default parameters.

## Timing
- Reset values: state IDLE. All outputs 0, including adc_count, row_sel and col_group.
- Reset asserted mid-frame aborts immediately with no partial-beat completion. After deassertion the block waits in IDLE for a new start.
- All outputs are registered or decoded from registered state only. No combinational path from start or out_ready to any output.
- busy rises the cycle after start is accepted. It falls the cycle after the final transfer when continuous=0.
- Frame length at default parameters with out_ready tied high: 1 (IDLE accept) + 5 + E + 256 + 36 cycles, where E is the exposure count.
- first_beat and last_beat are only asserted while out_valid=1. For a 1×1-group array both are asserted on the same beat.

## Test plan
- Single frame, defaults, expose_cycles=10, out_ready=1: erase high 5 cycles, expose high 10, convert high 256 with adc_count 0..255, then 36 beats with row/group ordering (0,0),(0,1),(0,2),(1,0)…(11,2); busy drops; IDLE.
- Backpressure: toggle out_ready every other cycle, plus a 7-cycle stall on beat (5,1): selects hold and out_valid stays high through stalls; exactly 36 transfers; last_beat only on (11,2).
- expose_cycles=0 and expose_cycles=16'hFFFF: exposure lasts 1 and 65535 cycles respectively.
- continuous=1, then change expose_cycles 10→20 during READ: second frame ERASE starts the cycle after the final transfer and exposes for 20 cycles; start pulses during the frame are ignored.
- Reset asserted mid-CONVERT (adc_count=100) and mid-READ (beat (6,1)): all outputs 0 asynchronously; a new start runs a full clean frame.
- Parameter sweep HEIGHT=1, WIDTH=8: one beat with first_beat=last_beat=1.

Source files
------------

// File: rtl/pixel_sensor_sequencer.sv
// Frame sequencer for the pixel array: erase, expose, ADC ramp convert, then
// row/column-group readout over a valid/ready output bus.
`timescale 1ns/1ps
module pixel_sensor_sequencer #(
  parameter int unsigned PIXEL_ARRAY_HEIGHT = 12,
  parameter int unsigned PIXEL_ARRAY_WIDTH  = 24,
  parameter int unsigned PIXEL_BITS         = 8,
  parameter int unsigned OUTPUT_BUS_WIDTH   = 8,
  parameter int unsigned ERASE_CYCLES       = 5,
  localparam int unsigned GROUPS = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH,
  localparam int unsigned RW = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
  localparam int unsigned GW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [15:0]           expose_cycles,
  input  logic                  out_ready,
  output logic                  erase,
  output logic                  expose,
  output logic                  convert,
  output logic [PIXEL_BITS-1:0] adc_count,
  output logic [RW-1:0]         row_sel,
  output logic [GW-1:0]         col_group,
  output logic                  out_valid,
  output logic                  first_beat,
  output logic                  last_beat,
  output logic                  busy
);

  // Phase counter is shared by erase, expose and convert; wide enough for both.
  localparam int unsigned CW        = (PIXEL_BITS + 1 > 16) ? PIXEL_BITS + 1 : 16;
  localparam int unsigned CONV_LAST = (32'd1 << PIXEL_BITS) - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [15:0]     exp_q, exp_d;
  logic [15:0]     exp_lat;
  logic [RW-1:0]   row_d;
  logic [GW-1:0]   col_d;
  logic            xfer;
  logic            erase_d, expose_d, convert_d, valid_d, first_d, last_d, busy_d;
  logic [PIXEL_BITS-1:0] adc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      exp_q      <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      adc_count  <= '0;
      row_sel    <= '0;
      col_group  <= '0;
      out_valid  <= 1'b0;
      first_beat <= 1'b0;
      last_beat  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      exp_q      <= exp_d;
      erase      <= erase_d;
      expose     <= expose_d;
      convert    <= convert_d;
      adc_count  <= adc_d;
      row_sel    <= row_d;
      col_group  <= col_d;
      out_valid  <= valid_d;
      first_beat <= first_d;
      last_beat  <= last_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    exp_d   = exp_q;
    row_d   = row_sel;
    col_d   = col_group;
    exp_lat = (expose_cycles == 16'd0) ? 16'd1 : expose_cycles;
    xfer    = out_valid && out_ready;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_ERASE;
          cnt_d   = '0;
          exp_d   = exp_lat;
        end
      end
      S_ERASE: begin
        if (cnt == CW'(ERASE_CYCLES - 1)) begin
          state_d = S_EXPOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_EXPOSE: begin
        if (cnt == CW'(exp_q - 16'd1)) begin
          state_d = S_CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_CONVERT: begin
        if (cnt == CW'(CONV_LAST)) begin
          state_d = S_READ;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_READ: begin
        if (xfer) begin
          if (col_group == GW'(GROUPS - 1)) begin
            col_d = '0;
            if (row_sel == RW'(PIXEL_ARRAY_HEIGHT - 1)) begin
              // Final beat: chain straight into the next frame or go idle.
              row_d = '0;
              cnt_d = '0;
              if (continuous) begin
                state_d = S_ERASE;
                exp_d   = exp_lat;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              row_d = row_sel + RW'(1);
            end
          end else begin
            col_d = col_group + GW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        row_d   = '0;
        col_d   = '0;
      end
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    erase_d   = (state_d == S_ERASE);
    expose_d  = (state_d == S_EXPOSE);
    convert_d = (state_d == S_CONVERT);
    adc_d     = convert_d ? cnt_d[PIXEL_BITS-1:0] : '0;
    valid_d   = (state_d == S_READ);
    first_d   = valid_d && (row_d == '0) && (col_d == '0);
    last_d    = valid_d && (row_d == RW'(PIXEL_ARRAY_HEIGHT - 1)) && (col_d == GW'(GROUPS - 1));
    busy_d    = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_pixel_sensor_sequencer.sv
// Scoreboard bench for pixel_sensor_sequencer: stimulus queues expected phase
// lengths and beats, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_pixel_sensor_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] expose_cycles = 16'd0;
  logic        out_ready = 1'b1;
  logic        erase, expose, convert, out_valid, first_beat, last_beat, busy;
  logic [7:0]  adc_count;
  logic [3:0]  row_sel;
  logic [1:0]  col_group;

  logic        start2 = 1'b0;
  logic        ready2 = 1'b1;
  logic        d2_erase, d2_expose, d2_convert, d2_valid, d2_first, d2_last, d2_busy;
  logic [7:0]  d2_adc;
  logic [0:0]  d2_row, d2_col;

  int tests = 0;
  int fails = 0;
  logic [7:0] beat_q[$];
  logic [3:0] beat2_q[$];
  int phase_q[$];
  int xfer_cnt = 0, xfer2_cnt = 0, busy_cycles = 0, busy2_cycles = 0;
  int rdy_mode = 0, stall_cnt = 0;

  int erase_run = 0, expose_run = 0, conv_run = 0;
  logic p_valid = 1'b0, p_ready = 1'b0, p_xfer = 1'b0, p_last = 1'b0, p_cont = 1'b0;
  logic [3:0] p_row = '0;
  logic [1:0] p_col = '0;

  pixel_sensor_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .expose_cycles(expose_cycles), .out_ready(out_ready),
    .erase(erase), .expose(expose), .convert(convert), .adc_count(adc_count),
    .row_sel(row_sel), .col_group(col_group), .out_valid(out_valid),
    .first_beat(first_beat), .last_beat(last_beat), .busy(busy)
  );

  pixel_sensor_sequencer #(.PIXEL_ARRAY_HEIGHT(1), .PIXEL_ARRAY_WIDTH(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .continuous(1'b0),
    .expose_cycles(16'd3), .out_ready(ready2),
    .erase(d2_erase), .expose(d2_expose), .convert(d2_convert), .adc_count(d2_adc),
    .row_sel(d2_row), .col_group(d2_col), .out_valid(d2_valid),
    .first_beat(d2_first), .last_beat(d2_last), .busy(d2_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic phase_end(input string name, input int run);
    if (phase_q.size() == 0) check({name, "_unexpected"}, 64'(run), 64'd0);
    else check(name, 64'(run), 64'(phase_q.pop_front()));
  endtask

  task automatic check_zero(input string name);
    check(name, 64'({erase, expose, convert, adc_count, row_sel, col_group,
                     out_valid, first_beat, last_beat, busy}), 64'd0);
  endtask

  task automatic push_frame(input int e);
    phase_q.push_back(5);
    phase_q.push_back((e == 0) ? 1 : e);
    phase_q.push_back(256);
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 3; c++)
        beat_q.push_back({4'(r), 2'(c), 1'(r == 0 && c == 0), 1'(r == 11 && c == 2)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic frame_done(input string name, input int exp_busy, input int exp_xfer);
    int n = 0;
    @(negedge clk);
    while (busy && n < 80000) begin @(negedge clk); n++; end
    check({name, "_idle"}, 64'(busy), 64'd0);
    if (exp_busy >= 0) check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    check({name, "_xfers"}, 64'(xfer_cnt), 64'(exp_xfer));
    check({name, "_beats_left"}, 64'(beat_q.size()), 64'd0);
    check({name, "_phases_left"}, 64'(phase_q.size()), 64'd0);
  endtask

  task automatic do_reset(input string name);
    #2 reset = 1'b1;
    #1 check_zero(name);
    beat_q.delete();
    phase_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    check({name, "_stay_idle"}, 64'(busy), 64'd0);
  endtask

  // Ready generator: always-ready, or toggling with a 7-cycle stall on beat (5,1).
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (out_valid && row_sel == 4'd5 && col_group == 2'd1 && stall_cnt < 7) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else out_ready = ~out_ready;
  end

  // Main monitor: phase lengths, ramp, handshake stability and beat scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      erase_run = 0; expose_run = 0; conv_run = 0;
      p_valid = 1'b0; p_ready = 1'b0; p_xfer = 1'b0; p_last = 1'b0; p_cont = 1'b0;
    end else begin
      if (busy) busy_cycles++;
      check("adc_count", 64'(adc_count), 64'(convert ? conv_run : 0));
      if (erase) erase_run++;
      else if (erase_run != 0) begin phase_end("erase_len", erase_run); erase_run = 0; end
      if (expose) expose_run++;
      else if (expose_run != 0) begin phase_end("expose_len", expose_run); expose_run = 0; end
      if (convert) conv_run++;
      else if (conv_run != 0) begin phase_end("convert_len", conv_run); conv_run = 0; end
      if (p_valid && !p_ready) begin
        check("valid_hold", 64'(out_valid), 64'd1);
        check("sel_hold", 64'({row_sel, col_group}), 64'({p_row, p_col}));
      end
      if (p_xfer && p_last) begin
        if (p_cont) check("cont_erase", 64'(erase), 64'd1);
        else check("busy_fall", 64'(busy), 64'd0);
      end
      if (!out_valid) check("flags_idle", 64'({first_beat, last_beat}), 64'd0);
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (beat_q.size() == 0)
          check("beat_extra", 64'({row_sel, col_group, first_beat, last_beat}), 64'h100);
        else
          check("beat", 64'({row_sel, col_group, first_beat, last_beat}), 64'(beat_q.pop_front()));
      end
      p_valid = out_valid; p_ready = out_ready; p_xfer = out_valid && out_ready;
      p_last = last_beat; p_cont = continuous; p_row = row_sel; p_col = col_group;
    end
  end

  // Single-beat array monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (d2_busy) busy2_cycles++;
      if (d2_valid && ready2) begin
        xfer2_cnt++;
        if (beat2_q.size() == 0)
          check("beat2_extra", 64'({d2_row, d2_col, d2_first, d2_last}), 64'h10);
        else
          check("beat2", 64'({d2_row, d2_col, d2_first, d2_last}), 64'(beat2_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    #1 check_zero("reset_init");
    check("reset_init_dut2", 64'({d2_erase, d2_expose, d2_convert, d2_adc, d2_row, d2_col,
                                  d2_valid, d2_first, d2_last, d2_busy}), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single frame, exposure 10, always ready.
    expose_cycles = 16'd10; push_frame(10); xfer_cnt = 0; busy_cycles = 0;
    pulse_start();
    frame_done("single", 307, 36);
    check_zero("single_after");

    // Backpressure with toggling ready and a stall on beat (5,1).
    rdy_mode = 1; stall_cnt = 0;
    push_frame(10); xfer_cnt = 0; busy_cycles = 0;
    pulse_start();
    frame_done("backpressure", -1, 36);
    check("stall_seen", 64'(stall_cnt), 64'd7);
    @(posedge clk); #1 rdy_mode = 0;

    // Exposure boundaries.
    expose_cycles = 16'd0; push_frame(0); xfer_cnt = 0; busy_cycles = 0;
    pulse_start();
    frame_done("expose0", 298, 36);
    expose_cycles = 16'hFFFF; push_frame(65535); xfer_cnt = 0; busy_cycles = 0;
    pulse_start();
    frame_done("exposeFFFF", 65832, 36);

    // Continuous capture with exposure re-latched during readout; stray starts ignored.
    continuous = 1'b1; expose_cycles = 16'd10;
    push_frame(10); push_frame(20); xfer_cnt = 0; busy_cycles = 0;
    pulse_start();
    n = 0;
    while (!out_valid && n < 2000) begin @(negedge clk); n++; end
    check("cont_reach_read", 64'(out_valid), 64'd1);
    @(posedge clk); #1 expose_cycles = 16'd20;
    pulse_start();
    n = 0;
    while (!erase && n < 2000) begin @(negedge clk); n++; end
    check("cont_second_erase", 64'(erase), 64'd1);
    @(posedge clk); #1 continuous = 1'b0;
    pulse_start();
    frame_done("continuous", 624, 72);
    repeat (5) @(negedge clk);
    check("start_not_queued", 64'(busy), 64'd0);

    // Reset in the middle of convert.
    expose_cycles = 16'd10; push_frame(10);
    pulse_start();
    n = 0;
    while (!(convert && adc_count == 8'd100) && n < 2000) begin @(negedge clk); n++; end
    check("reach_adc100", 64'(adc_count), 64'd100);
    do_reset("reset_convert");

    // Reset in the middle of readout.
    push_frame(10);
    pulse_start();
    n = 0;
    while (!(out_valid && row_sel == 4'd6 && col_group == 2'd1) && n < 2000) begin
      @(negedge clk); n++;
    end
    check("reach_beat_6_1", 64'({out_valid, row_sel, col_group}), 64'({1'b1, 4'd6, 2'd1}));
    do_reset("reset_read");

    // Clean frame after the aborts.
    push_frame(10); xfer_cnt = 0; busy_cycles = 0;
    pulse_start();
    frame_done("post_reset", 307, 36);

    // One-row, one-group array: a single beat carrying both markers.
    beat2_q.push_back(4'b0011); xfer2_cnt = 0; busy2_cycles = 0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    n = 0;
    @(negedge clk);
    while (d2_busy && n < 2000) begin @(negedge clk); n++; end
    check("sweep_idle", 64'(d2_busy), 64'd0);
    check("sweep_xfers", 64'(xfer2_cnt), 64'd1);
    check("sweep_busy_cycles", 64'(busy2_cycles), 64'd265);
    check("sweep_beats_left", 64'(beat2_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
